// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spiking-neural-network layer controllers:
//   POT_W              membrane potential / synaptic current width (16 bits)
//   THRESHOLD_DEFAULT  default signed firing threshold
//   state_t / ST_*     scheduler state encoding
//   sat16()            clamp a 17-bit signed sum into the 16-bit signed range
// -----------------------------------------------------------------------------
package snn_pkg;

  localparam int POT_W = 16;

  localparam logic signed [POT_W-1:0] THRESHOLD_DEFAULT = 16'sh0960;

  // Scheduler state encoding, kept as plain constants so older controllers
  // that compare against raw codes keep working.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WAIT_STEP = 3'd1;
  localparam state_t ST_REQ       = 3'd2;
  localparam state_t ST_UPDATE    = 3'd3;
  localparam state_t ST_FINISH    = 3'd4;

  // The sum of two 16-bit signed values always fits in 17 bits, so a single
  // range check against the 16-bit limits is enough to saturate.
  function automatic logic signed [POT_W-1:0] sat16(input logic signed [POT_W:0] sum);
    if (sum > 17'sd32767) begin
      return 16'sh7FFF;
    end else if (sum < -17'sd32768) begin
      return 16'sh8000;
    end else begin
      return sum[POT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/lif_update.sv
// -----------------------------------------------------------------------------
// lif_update
// Combinational integrate-and-fire step for one neuron, no leak.
//   pot_in   current membrane potential (signed)
//   cur_in   synaptic current to integrate (signed)
//   pot_out  potential to write back: 0 after a spike, else the saturated sum
//   fire     saturated sum reached THRESHOLD
// -----------------------------------------------------------------------------
module lif_update
  import snn_pkg::*;
#(
  parameter logic signed [POT_W-1:0] THRESHOLD = THRESHOLD_DEFAULT
) (
  input  logic signed [POT_W-1:0] pot_in,
  input  logic signed [POT_W-1:0] cur_in,
  output logic signed [POT_W-1:0] pot_out,
  output logic                    fire
);

  logic signed [POT_W:0]   sum;
  logic signed [POT_W-1:0] sat;

  always_comb begin
    // Sign-extend both operands by one bit so the add cannot overflow.
    sum     = {pot_in[POT_W-1], pot_in} + {cur_in[POT_W-1], cur_in};
    sat     = sat16(sum);
    fire    = (sat >= THRESHOLD);
    pot_out = fire ? '0 : sat;
  end

endmodule

// File: rtl/snn_layer_scheduler.sv
// -----------------------------------------------------------------------------
// snn_layer_scheduler
// Time-multiplexes N_NEURONS integrate-and-fire neurons over a window of
// T_WINDOW timesteps, fetching each neuron's synaptic current through a
// req/ack handshake and reporting the neuron with the most spikes.
//   clk, rst            clock, synchronous active-high reset
//   start               begin a window (ignored while busy)
//   step_en             permits the next timestep sweep to begin
//   cur_req/cur_idx     current request for neuron cur_idx
//   cur_ack/cur_data    current returned for the requested neuron
//   spk_valid/spk_idx/spk  one pulse per neuron update, spk = fired
//   busy, done          window in progress / one-cycle end-of-window pulse
//   win_idx/win_cnt     winning neuron and its spike count
// -----------------------------------------------------------------------------
module snn_layer_scheduler
  import snn_pkg::*;
#(
  parameter int                N_NEURONS = 8,
  parameter int                T_WINDOW  = 250,
  parameter logic signed [15:0] THRESHOLD = THRESHOLD_DEFAULT,
  parameter int                CNT_W     = 8,
  localparam int               IDX_W     = $clog2(N_NEURONS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    step_en,
  output logic                    cur_req,
  output logic [IDX_W-1:0]        cur_idx,
  input  logic                    cur_ack,
  input  logic signed [POT_W-1:0] cur_data,
  output logic                    spk_valid,
  output logic [IDX_W-1:0]        spk_idx,
  output logic                    spk,
  output logic                    busy,
  output logic                    done,
  output logic [IDX_W-1:0]        win_idx,
  output logic [CNT_W-1:0]        win_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic [15:0]      LAST_TS  = 16'(T_WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t                  state;
  logic [IDX_W-1:0]        index;
  logic [15:0]             timestep;
  logic signed [POT_W-1:0] cur_q;
  logic signed [POT_W-1:0] pot [N_NEURONS];
  logic [CNT_W-1:0]        cnt [N_NEURONS];
  logic [IDX_W-1:0]        win_idx_q;
  logic [CNT_W-1:0]        win_cnt_q;
  logic [IDX_W-1:0]        best_idx;
  logic [CNT_W-1:0]        best_cnt;
  logic signed [POT_W-1:0] upd_pot;
  logic                    upd_fire;

  // Single shared update datapath: only the neuron at 'index' is evaluated.
  lif_update #(
    .THRESHOLD(THRESHOLD)
  ) u_lif (
    .pot_in (pot[index]),
    .cur_in (cur_q),
    .pot_out(upd_pot),
    .fire   (upd_fire)
  );

  // Strict '>' while scanning upward keeps the lowest index on ties, and an
  // all-zero count array leaves the defaults (index 0, count 0).
  always_comb begin
    best_idx = '0;
    best_cnt = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (cnt[i] > best_cnt) begin
        best_cnt = cnt[i];
        best_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      index     <= '0;
      timestep  <= '0;
      cur_q     <= '0;
      spk_valid <= 1'b0;
      spk       <= 1'b0;
      spk_idx   <= '0;
      win_idx_q <= '0;
      win_cnt_q <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        pot[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      spk_valid <= 1'b0;
      spk       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_WAIT_STEP;
            index    <= '0;
            timestep <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
              pot[i] <= '0;
              cnt[i] <= '0;
            end
          end
        end
        ST_WAIT_STEP: begin
          if (step_en) begin
            state <= ST_REQ;
            index <= '0;
          end
        end
        ST_REQ: begin
          // No timeout: the current source may stall for as long as it needs.
          if (cur_ack) begin
            cur_q <= cur_data;
            state <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          pot[index] <= upd_pot;
          if (upd_fire && (cnt[index] != CNT_MAX)) begin
            cnt[index] <= cnt[index] + 1'b1;
          end
          spk_valid <= 1'b1;
          spk       <= upd_fire;
          spk_idx   <= index;
          if (index != LAST_IDX) begin
            index <= index + 1'b1;
            state <= ST_REQ;
          end else begin
            timestep <= timestep + 1'b1;
            state    <= (timestep == LAST_TS) ? ST_FINISH : ST_WAIT_STEP;
          end
        end
        ST_FINISH: begin
          win_idx_q <= best_idx;
          win_cnt_q <= best_cnt;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cur_req = (state == ST_REQ);
  assign cur_idx = index;
  assign busy    = (state != ST_IDLE) && (state != ST_FINISH);
  assign done    = (state == ST_FINISH);

  // The winner is presented combinationally during the done cycle (the last
  // count update lands on the edge entering FINISH) and held afterwards.
  assign win_idx = done ? best_idx : win_idx_q;
  assign win_cnt = done ? best_cnt : win_cnt_q;

endmodule

// File: tb/tb_snn_layer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_snn_layer_scheduler
// Self-checking bench for snn_layer_scheduler (N=2, T_WINDOW=8). A responder
// serves current requests, a reference model tracks potentials and spike
// counts from the integrate-and-fire rules, and directed windows cover the
// single-spiker, tie, stalled-ack, paced-step, saturation, random and
// mid-window reset cases.
// -----------------------------------------------------------------------------
module tb_snn_layer_scheduler;

  localparam int N   = 2;
  localparam int T   = 8;
  localparam int CW  = 8;
  localparam int THR = 2400;
  localparam int IW  = $clog2(N);

  logic              clk;
  logic              rst;
  logic              start;
  logic              step_en;
  logic              cur_req;
  logic [IW-1:0]     cur_idx;
  logic              cur_ack;
  logic signed [15:0] cur_data;
  logic              spk_valid;
  logic [IW-1:0]     spk_idx;
  logic              spk;
  logic              busy;
  logic              done;
  logic [IW-1:0]     win_idx;
  logic [CW-1:0]     win_cnt;

  snn_layer_scheduler #(
    .N_NEURONS(N),
    .T_WINDOW (T),
    .THRESHOLD(16'sh0960),
    .CNT_W    (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .step_en  (step_en),
    .cur_req  (cur_req),
    .cur_idx  (cur_idx),
    .cur_ack  (cur_ack),
    .cur_data (cur_data),
    .spk_valid(spk_valid),
    .spk_idx  (spk_idx),
    .spk      (spk),
    .busy     (busy),
    .done     (done),
    .win_idx  (win_idx),
    .win_cnt  (win_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Stimulus configuration
  int cur_mode  = 0;
  int cur_const [N];
  int ack_delay = 0;
  int step_mode = 0;
  logic step_rand   = 1'b1;
  logic step_manual = 1'b0;

  // Reference model and bookkeeping
  int pot_m [N];
  int cnt_m [N];
  int issued_val [$];
  int issued_idx [$];
  int req_num    = 0;
  int n_updates  = 0;
  int orphan_spk = 0;
  int stab_err   = 0;
  int done_seen  = 0;

  assign step_en = (step_mode == 0) ? 1'b1 : (step_mode == 1) ? step_rand : step_manual;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int model_win_idx();
    int b = 0;
    for (int i = 1; i < N; i++) if (cnt_m[i] > cnt_m[b]) b = i;
    return b;
  endfunction

  function automatic int pick_current(input int n, input int ts);
    logic signed [15:0] r;
    if (cur_mode == 0) return cur_const[n];
    if (cur_mode == 2) return (n == 0 && ts < 4) ? -32768 : 32767;
    case ($urandom_range(0, 4))
      0: return -32768;
      1: return 32767;
      2: return int'($urandom_range(0, 3000));
      3: return -int'($urandom_range(0, 3000));
      default: begin
        r = 16'($urandom);
        return int'(r);
      end
    endcase
  endfunction

  // Current source: optional stall, then a one-cycle ack with data.
  initial begin : responder
    int ack_wait;
    int v;
    logic [IW-1:0] held_idx;
    ack_wait = 0;
    held_idx = '0;
    cur_ack  = 1'b0;
    cur_data = '0;
    forever begin
      @(negedge clk);
      cur_ack = 1'b0;
      if (cur_req && !rst) begin
        if (ack_wait == 0) held_idx = cur_idx;
        else if (cur_idx !== held_idx) stab_err++;
        if (ack_wait >= ack_delay) begin
          v        = pick_current(int'(cur_idx), req_num / N);
          cur_data = 16'(v);
          cur_ack  = 1'b1;
          issued_val.push_back(v);
          issued_idx.push_back(int'(cur_idx));
          req_num++;
          ack_wait = 0;
        end else begin
          ack_wait++;
        end
      end else begin
        ack_wait = 0;
      end
    end
  end

  initial begin : step_driver
    forever begin
      @(negedge clk);
      step_rand = 1'(($urandom % 3) != 0);
    end
  end

  // Reference model: each reported update consumes the oldest served current.
  always @(negedge clk) begin
    int v, n, s;
    logic fire;
    if (done) done_seen++;
    if (spk_valid) begin
      if (issued_val.size() == 0) begin
        orphan_spk++;
      end else begin
        v = issued_val.pop_front();
        n = issued_idx.pop_front();
        s = pot_m[n] + v;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        fire = (s >= THR);
        if (fire) begin
          pot_m[n] = 0;
          if (cnt_m[n] < (1 << CW) - 1) cnt_m[n]++;
        end else begin
          pot_m[n] = s;
        end
        checkOutput("spk_idx", spk_idx, n);
        checkOutput("spk", spk, fire);
        n_updates++;
      end
    end
  end

  task automatic applyStimulus(input int mode, input int delay, input int smode);
    @(negedge clk);
    cur_mode  = mode;
    ack_delay = delay;
    step_mode = smode;
    for (int i = 0; i < N; i++) begin
      pot_m[i] = 0;
      cnt_m[i] = 0;
    end
    issued_val.delete();
    issued_idx.delete();
    req_num    = 0;
    n_updates  = 0;
    orphan_spk = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
  endtask

  task automatic finishWindow(input bit start_on_done);
    int cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      checkOutput("done_timeout", done, 1);
      return;
    end
    #1;
    checkOutput("win_idx", win_idx, model_win_idx());
    checkOutput("win_cnt", win_cnt, cnt_m[model_win_idx()]);
    checkOutput("n_updates", n_updates, N * T);
    checkOutput("pending_currents", issued_val.size(), 0);
    checkOutput("orphan_spk", orphan_spk, 0);
    checkOutput("busy_at_done", busy, 0);
    if (start_on_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_done", busy, 0);
    checkOutput("done_one_cycle", done, 0);
    checkOutput("win_cnt_held", win_cnt, cnt_m[model_win_idx()]);
  endtask

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int cyc;
    int req_seen;
    int done_before;
    rst         = 1'b1;
    start       = 1'b0;
    step_mode   = 0;
    cur_const[0] = 600;
    cur_const[1] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_cur_req", cur_req, 0);
    checkOutput("rst_spk_valid", spk_valid, 0);
    checkOutput("rst_win_cnt", win_cnt, 0);
    rst = 1'b0;

    // Neuron 0 at 600 spikes at timesteps 3 and 7; start on done is ignored
    $display("[TB] single spiker window");
    applyStimulus(0, 0, 0);
    finishWindow(1'b1);
    checkOutput("single_win_idx", win_idx, 0);
    checkOutput("single_win_cnt", win_cnt, 2);

    // Start the cycle after done is accepted; both neurons tie every step
    $display("[TB] tie window");
    cur_const[0] = 2400;
    cur_const[1] = 2400;
    applyStimulus(0, 0, 0);
    finishWindow(1'b0);
    checkOutput("tie_win_idx", win_idx, 0);
    checkOutput("tie_win_cnt", win_cnt, 8);

    // Stalled acknowledge: request held stable, same results
    $display("[TB] delayed ack window");
    cur_const[0] = 600;
    cur_const[1] = 0;
    stab_err = 0;
    applyStimulus(0, 5, 0);
    finishWindow(1'b0);
    checkOutput("req_stable", stab_err, 0);
    checkOutput("delay_win_cnt", win_cnt, 2);

    // step_en held low: no requests while waiting; start during busy ignored
    $display("[TB] paced step window");
    step_manual = 1'b0;
    applyStimulus(0, 0, 2);
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cur_req) req_seen++;
      start = (i == 4);
    end
    start = 1'b0;
    checkOutput("no_req_first_step", req_seen, 0);
    step_manual = 1'b1;
    cyc = 0;
    while (n_updates < N && cyc < 500) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    step_manual = 1'b0;
    checkOutput("first_sweep_updates", n_updates, N);
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cur_req) req_seen++;
      start = (i == 3);
    end
    start = 1'b0;
    checkOutput("no_req_between_steps", req_seen, 0);
    checkOutput("busy_while_waiting", busy, 1);
    step_manual = 1'b1;
    finishWindow(1'b0);
    checkOutput("paced_win_cnt", win_cnt, 2);

    // Saturation at both rails
    $display("[TB] saturation window");
    applyStimulus(2, 0, 0);
    finishWindow(1'b0);
    checkOutput("sat_win_idx", win_idx, 1);
    checkOutput("sat_win_cnt", win_cnt, 8);

    // Randomized currents, stalls and step pacing
    for (int w = 0; w < 6; w++) begin
      $display("[TB] random window %0d", w);
      applyStimulus(1, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
      finishWindow(1'(w % 2));
    end

    // Reset during the request of timestep 3
    $display("[TB] mid-window reset");
    cur_const[0] = 600;
    cur_const[1] = 0;
    applyStimulus(0, 20, 0);
    cyc = 0;
    while (!(req_num == 3 * N && cur_req) && cyc < 1000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    checkOutput("reached_ts3_req", cur_req, 1);
    done_before = done_seen;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_cur_req", cur_req, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_spk_valid", spk_valid, 0);
    checkOutput("mid_rst_spk", spk, 0);
    checkOutput("mid_rst_win_idx", win_idx, 0);
    checkOutput("mid_rst_win_cnt", win_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("no_done_after_rst", done_seen, done_before);
    checkOutput("idle_after_rst", busy, 0);

    // Clean window after reset
    applyStimulus(0, 0, 0);
    finishWindow(1'b0);
    checkOutput("post_rst_win_idx", win_idx, 0);
    checkOutput("post_rst_win_cnt", win_cnt, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/snn_layer_scheduler.md
SNN_LAYER_SCHEDULER -- requirements
Module: snn_layer_scheduler

Interface
REQ-001 Parameter N_NEURONS, default 8, number of time-multiplexed integrate-and-fire neurons (2..64).
REQ-002 Parameter T_WINDOW, default 250, timesteps per inference window (1..65535).
REQ-003 Parameter THRESHOLD, default 16'sh0960, signed firing threshold.
REQ-004 Parameter CNT_W, default 8, spike-counter width.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  one-cycle pulse; begins a window; ignored while busy=1.
REQ-008 step_en  input  1  timestep pacing; a new timestep sweep begins only when step_en=1.
REQ-009 cur_req  output  1  request for synaptic current of neuron cur_idx.
REQ-010 cur_idx  output  clog2(N_NEURONS)  neuron index requested; stable while cur_req=1.
REQ-011 cur_ack  input  1  current source returns cur_data this cycle; valid only while cur_req=1.
REQ-012 cur_data  input  16 signed  synaptic current for cur_idx.
REQ-013 spk_valid  output  1  one-cycle pulse per neuron update.
REQ-014 spk_idx  output  clog2(N_NEURONS)  neuron updated.
REQ-015 spk  output  1  neuron fired on this update; qualified by spk_valid.
REQ-016 busy  output  1  window in progress.
REQ-017 done  output  1  one-cycle pulse at window end.
REQ-018 win_idx / win_cnt  output  clog2(N_NEURONS) / CNT_W  winning neuron and its spike count; held until next start.

Function
REQ-019 States: IDLE, WAIT_STEP, REQ, UPDATE, FINISH.
REQ-020 IDLE->WAIT_STEP on start: clear all potentials and counters, timestep=0, busy=1.
REQ-021 WAIT_STEP->REQ when step_en=1, neuron index=0.
REQ-022 REQ: cur_req=1, cur_idx=index; on cur_ack capture cur_data, drop cur_req next cycle, go UPDATE; no timeout, wait indefinitely.
REQ-023 UPDATE (one cycle): new=sat16(pot[index]+cur_data); if new>=THRESHOLD then spk=1, pot[index]=0, count[index] +1 saturating at 2^CNT_W-1; else spk=0, pot[index]=new; spk_valid=1 this cycle.
REQ-024 sat16 clamps to [-32768, 32767]; negative potentials are retained, no leak.
REQ-025 After UPDATE: index<N_NEURONS-1 -> REQ with index+1; else timestep+1; if timestep reached T_WINDOW -> FINISH else WAIT_STEP.
REQ-026 FINISH (one cycle): win_idx = lowest index with maximal count, win_cnt = that count, done=1, busy=0, next state IDLE.
REQ-027 Minimum latency per neuron update: 3 cycles (REQ with same-cycle ack, capture, UPDATE).
REQ-028 start coincident with done is ignored; start in IDLE the cycle after done is accepted.
REQ-029 All-zero counts: win_idx=0, win_cnt=0.

Reset
REQ-030 rst forces IDLE and zeroes potentials, counters, timestep, index, cur_req, spk_valid, spk, busy, done, win_idx, win_cnt; rst wins over all other inputs.
REQ-031 rst mid-window abandons the window without done; cur_req drops the following cycle.

Structure
REQ-032 Package snn_pkg holds THRESHOLD default, potential width (16), state enum, sat16 function.
REQ-033 One sub-module lif_update: combinational saturating add, threshold compare, reset-to-zero; shared by future layer controllers.
REQ-034 Potentials and counters held in register arrays indexed by neuron; single update port.

Verification
REQ-035 N=2, T_WINDOW=8, neuron0 current 600, neuron1 0, step_en=1, ack same cycle -> neuron0 spikes at timesteps 3,7; done; win_idx=0, win_cnt=2.
REQ-036 Current 32767 repeated -> potential saturates, then spike and reset to 0; no wrap to negative.
REQ-037 Both neurons current 2400 -> both spike every timestep; counts tie at 8; win_idx=0.
REQ-038 cur_ack delayed 5 cycles -> cur_req/cur_idx held stable; no spk_valid until ack; results unchanged.
REQ-039 rst asserted during REQ of timestep 3 -> next cycle IDLE, all outputs 0, no done; new start yields clean window.
REQ-040 step_en low for 10 cycles between timesteps -> scheduler waits in WAIT_STEP, no cur_req; start pulse during busy ignored.
